fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupling FIFO between the fetch stage and decode. Buffers fetch_data_t
//  entries (pc, data, bp) so fetch can run ahead while decode stalls on
//  rename back-pressure or on its own uop (jal/jalr) expansion cycles.
//  Flushed entirely on squash. Output is registered storage: no
//  combinational path from in_i to out_o, and none from out_o_ready to in_i_ready.
// PARAMETERS
//  DEPTH  4  number of entries; power of two, >= 2
// PORTS
//  clk          in   1                    clock
//  rstn         in   1                    reset, asynchronous, active-low
//  in_i         in   $bits(fetch_data_t)  fetched instruction {pc, data, bp}
//  in_i_valid   in   1                    fetch offers in_i
//  in_i_ready   out  1                    queue accepts in_i this cycle
//  out_o        out  $bits(fetch_data_t)  head entry, to decode in_i
//  out_o_valid  out  1                    head entry valid, to decode in_i_valid
//  out_o_ready  in   1                    decode consumes head, from decode in_i_ready
//  count_o      out  $clog2(DEPTH+1)      current occupancy (debug/perf)
//  squash_io    squash_if.slave           squash_io.valid flushes the queue
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rstn); all state
//    is clocked on posedge clk and cleared on negedge rstn.
//  - Storage: DEPTH x fetch_data_t array, not reset. Read and write pointers
//    are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//    empty = (rptr == wptr); full = (index bits equal && wrap bits differ).
//  - Reset values: rptr = wptr = 0, so count_o = 0, out_o_valid = 0 and
//    in_i_ready = 1 from the first cycle after reset release. out_o is a
//    don't-care while out_o_valid = 0.
//  - in_i_ready  = !full && !squash_io.valid.
//  - out_o_valid = !empty && !squash_io.valid.
//  - out_o = mem[rptr index], a combinational read of the head entry.
//  - push = in_i_valid && in_i_ready: write mem[wptr], then wptr += 1 (mod 2*DEPTH).
//  - pop = out_o_valid && out_o_ready: rptr += 1 (mod 2*DEPTH).
//  - Latency: an entry pushed in cycle N is presented on out_o in cycle N+1
//    at the earliest (empty queue). No bypass.
//  - Push and pop in the same cycle: both take effect; count_o is unchanged.
//    When full, in_i_ready = 0 even if out_o_ready = 1, so there is no
//    fall-through; the freed slot is accepted in the next cycle.
//  - Squash (squash_io.valid = 1): at the next edge rptr = wptr = 0. Any
//    push or pop offered in that cycle is ignored (ready/valid are forced
//    low). Squash overrides every other event.
//  - count_o = wptr - rptr, computed with the wrap bit; range 0..DEPTH.
//  - Pointer wrap: the index wraps at DEPTH and the wrap bit toggles. FIFO
//    order is preserved across the wrap.
//  - Reset asserted mid-operation clears all entries immediately
//    (asynchronous); the contents are lost.
//  - Assertions: no push while full; no pop while empty; count_o <= DEPTH.
// STRUCTURE
//  - Package C: fetch_data_t (existing); add localparam FQ_DEPTH = 4 as the
//    top-level default.
//  - Single module with no sub-module. The pointer and full/empty logic is
//    inline, because the squash override is specific to this queue.
// TESTING
//  - Reset: after rstn rises -> out_o_valid=0, in_i_ready=1, count_o=0.
//  - Single entry: push pc=0x80000000 in cycle N -> out_o_valid=1 with
//    out_o.pc=0x80000000 in cycle N+1; pop -> count_o returns to 0.
//  - Fill: out_o_ready=0, push 5 entries (DEPTH=4) -> 4 accepted,
//    in_i_ready=0 on the 5th, count_o=4. Then drain -> pcs come out in order.
//  - Simultaneous: count_o=2, push and pop in the same cycle -> count_o stays
//    2; repeat for 10 cycles -> order is preserved across pointer wrap.
//  - Full with out_o_ready=1: in_i_ready=0 that cycle; next cycle
//    in_i_ready=1 and count_o=3.
//  - Squash: count_o=3, squash_io.valid=1 with in_i_valid=1 -> ready/valid
//    both low that cycle; next cycle count_o=0 and the offered entry is lost.
//  - Async reset: with count_o=2, drop rstn between edges -> out_o_valid=0
//    immediately, without waiting for an edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - fetch/decode shared types and fetch queue default depth
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        bp;
  } fetch_data_t;

  localparam int FQ_DEPTH = 4;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - squash broadcast interface consumed by the fetch queue
interface squash_if;
  logic valid;

  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - decoupling FIFO between fetch and decode, flushed on squash
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  fetch_data_t                in_i,
  input  logic                       in_i_valid,
  output logic                       in_i_ready,
  output fetch_data_t                out_o,
  output logic                       out_o_valid,
  input  logic                       out_o_ready,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  squash_if.slave                    squash_io
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_data_t   mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // MSB of each pointer is the wrap bit that disambiguates full from empty
  assign empty = (rptr == wptr);
  assign full  = (rptr[IW-1:0] == wptr[IW-1:0]) && (rptr[IW] != wptr[IW]);

  assign in_i_ready  = !full && !squash_io.valid;
  assign out_o_valid = !empty && !squash_io.valid;
  assign push        = in_i_valid && in_i_ready;
  assign pop         = out_o_valid && out_o_ready;
  assign out_o       = mem[rptr[IW-1:0]];
  assign count_o     = CW'(wptr - rptr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr <= '0;
      wptr <= '0;
    end else if (squash_io.valid) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[IW-1:0]] <= in_i;
  end

  assert property (@(posedge clk) disable iff (!rstn) !(in_i_valid && in_i_ready && full));
  assert property (@(posedge clk) disable iff (!rstn) !(out_o_valid && out_o_ready && empty));
  assert property (@(posedge clk) disable iff (!rstn) int'(count_o) <= DEPTH);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with randomized traffic
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = FQ_DEPTH;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  fetch_data_t                in_i;
  logic                       in_i_valid;
  logic                       in_i_ready;
  fetch_data_t                out_o;
  logic                       out_o_valid;
  logic                       out_o_ready;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  squash_if sq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_i        (in_i),
    .in_i_valid  (in_i_valid),
    .in_i_ready  (in_i_ready),
    .out_o       (out_o),
    .out_o_valid (out_o_valid),
    .out_o_ready (out_o_ready),
    .count_o     (count_o),
    .squash_io   (sq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  fetch_data_t ref_q [$];
  fetch_data_t sb [$];
  fetch_data_t mon_exp;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic fetch_data_t rnd_entry();
    fetch_data_t d;
    d.pc   = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    d.data = $urandom;
    d.bp   = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // Monitor: every handshake on the output must match the oldest outstanding entry
  always @(negedge clk) begin
    if (rstn && out_o_valid && out_o_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL out_pop_unexpected actual=pc %0h required=no entry", out_o.pc);
      end else begin
        mon_exp = sb.pop_front();
        if (out_o !== mon_exp) begin
          failures++;
          $display("FAIL out_o actual=%0h required=%0h", out_o, mon_exp);
        end
      end
    end
  end

  // One clock of stimulus plus reference-model bookkeeping, checked mid-cycle
  task automatic cycle(input bit v, input fetch_data_t d, input bit ordy, input bit squash);
    bit er;
    bit ev;
    @(posedge clk);
    #1;
    in_i_valid  = v;
    in_i        = d;
    out_o_ready = ordy;
    sq.valid    = squash;
    @(negedge clk);
    #1;
    er = (ref_q.size() < DEPTH) && !squash;
    ev = (ref_q.size() > 0) && !squash;
    chk("in_i_ready", in_i_ready, er);
    chk("out_o_valid", out_o_valid, ev);
    chk("count_o", count_o, ref_q.size());
    if (squash) begin
      ref_q.delete();
      sb.delete();
    end else begin
      if (ev && ordy) void'(ref_q.pop_front());
      if (er && v) begin
        ref_q.push_back(d);
        sb.push_back(d);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  fetch_data_t first;

  initial begin
    in_i        = '0;
    in_i_valid  = 1'b0;
    out_o_ready = 1'b0;
    sq.valid    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // reset state
    idle(1);

    // single entry, visible one cycle after the push, then popped
    first = rnd_entry();
    first.pc = 32'h8000_0000;
    cycle(1'b1, first, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // fill past capacity, then drain in order
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, rnd_entry(), 1'b0, 1'b0);
    idle(1);
    drain();

    // steady push+pop at occupancy 2 across pointer wrap
    cycle(1'b1, rnd_entry(), 1'b0, 1'b0);
    cycle(1'b1, rnd_entry(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd_entry(), 1'b1, 1'b0);
    idle(1);
    drain();

    // full with consumer ready: no fall-through, slot reopens next cycle
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd_entry(), 1'b0, 1'b0);
    cycle(1'b1, rnd_entry(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    drain();

    // squash with an offered entry: entry lost, queue empty
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_entry(), 1'b0, 1'b0);
    cycle(1'b1, rnd_entry(), 1'b1, 1'b1);
    idle(1);
    drain();

    // asynchronous reset between edges
    cycle(1'b1, rnd_entry(), 1'b0, 1'b0);
    cycle(1'b1, rnd_entry(), 1'b0, 1'b0);
    idle(1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("async_out_o_valid", out_o_valid, 1'b0);
    chk("async_count_o", count_o, 0);
    chk("async_in_i_ready", in_i_ready, 1'b1);
    ref_q.delete();
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_entry(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
    drain();
    chk("final_leftover", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
